// File: rtl/clock_defs.sv
// Shared definitions for the alarm clock controller: key codes, states,
// timeouts, HH:MM limits and BCD helpers.
package clock_defs;

    typedef enum logic [1:0] {
        SHOW_TIME  = 2'd0,
        KEY_ENTRY  = 2'd1,
        SHOW_ALARM = 2'd2
    } state_e;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] KEY_LOAD_TIME  = 4'hA;
    localparam logic [3:0] KEY_LOAD_ALARM = 4'hB;
    localparam logic [3:0] KEY_SHOW_ALARM = 4'hC;
    localparam logic [3:0] KEY_FAST       = 4'hD;
    localparam logic [3:0] KEY_STOP       = 4'hE;

    localparam logic [3:0] ENTRY_TIMEOUT = 4'd10;
    localparam logic [3:0] ALARM_TIMEOUT = 4'd4;
    localparam logic [3:0] SEC_MAX       = 4'd15;

    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MM_MAX = 8'h59;

    // Two-digit BCD increment without range wrap; callers handle the limit.
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        if (v[3:0] == BCD_DIGIT_MAX) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Unit digits must be real BCD so the numeric limit compare is meaningful.
    function automatic logic hhmm_valid(input logic [15:0] v);
        return (v[11:8] <= BCD_DIGIT_MAX) && (v[3:0] <= BCD_DIGIT_MAX) &&
               (v[15:8] <= HH_MAX) && (v[7:0] <= MM_MAX);
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// HH:MM BCD time register with load and minute increment; load wins over
// increment so a freshly loaded time is never advanced in the same cycle.
module bcd_time_counter
    import clock_defs::*;
(
    input  logic        clk256,
    input  logic        reset,
    input  logic        load_en,
    input  logic [15:0] load_val,
    input  logic        inc,
    output logic [15:0] time_next
);

    logic [15:0] time_q;
    logic [15:0] time_d;

    always_comb begin
        time_d = time_q;
        if (load_en) begin
            time_d = load_val;
        end else if (inc) begin
            if (time_q[7:0] == MM_MAX) begin
                time_d[7:0] = 8'h00;
                if (time_q[15:8] == HH_MAX) begin
                    time_d[15:8] = 8'h00;
                end else begin
                    time_d[15:8] = bcd_inc8(time_q[15:8]);
                end
            end else begin
                time_d[7:0] = bcd_inc8(time_q[7:0]);
            end
        end
    end

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            time_q <= 16'h0000;
        end else begin
            time_q <= time_d;
        end
    end

    // The parent registers its display and alarm compare from the next value.
    assign time_next = time_d;

endmodule

// File: rtl/clock_ctrl.sv
// Alarm clock controller: keypad FSM, entry buffer, alarm register, entry and
// alarm-view timeouts, fast-mode toggle and alarm annunciator.
module clock_ctrl
    import clock_defs::*;
(
    input  logic        clk256,
    input  logic        reset,
    input  logic        one_second,
    input  logic        one_minute,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        alarm_enable,
    output logic        fast_mode,
    output logic [15:0] disp_bcd,
    output logic [1:0]  disp_sel,
    output logic        sound_alarm
);

    state_e      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] alarm_q, alarm_d;
    logic [3:0]  sec_q, sec_d;
    logic        fast_q, fast_d;
    logic        sound_q, sound_d;
    logic [15:0] disp_bcd_q, disp_bcd_d;
    logic [1:0]  disp_sel_q, disp_sel_d;

    logic        time_load;
    logic [15:0] time_next;
    logic        stop_key;
    logic        alarm_hit;

    bcd_time_counter u_time (
        .clk256    (clk256),
        .reset     (reset),
        .load_en   (time_load),
        .load_val  (buf_q),
        .inc       (one_minute),
        .time_next (time_next)
    );

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        alarm_d   = alarm_q;
        fast_d    = fast_q;
        time_load = 1'b0;
        stop_key  = 1'b0;
        if (key_valid) begin
            if (key_code <= BCD_DIGIT_MAX) begin
                state_d = KEY_ENTRY;
                buf_d   = (state_q == KEY_ENTRY) ? {buf_q[11:0], key_code}
                                                 : {12'h000, key_code};
            end else begin
                case (key_code)
                    KEY_LOAD_TIME: begin
                        if (state_q == KEY_ENTRY) begin
                            state_d   = SHOW_TIME;
                            buf_d     = 16'h0000;
                            time_load = hhmm_valid(buf_q);
                        end
                    end
                    KEY_LOAD_ALARM: begin
                        if (state_q == KEY_ENTRY) begin
                            state_d = SHOW_TIME;
                            buf_d   = 16'h0000;
                            if (hhmm_valid(buf_q)) alarm_d = buf_q;
                        end
                    end
                    KEY_SHOW_ALARM: begin
                        if (state_q == SHOW_TIME)       state_d = SHOW_ALARM;
                        else if (state_q == SHOW_ALARM) state_d = SHOW_TIME;
                    end
                    KEY_FAST: fast_d   = ~fast_q;
                    KEY_STOP: stop_key = 1'b1;
                    default: ;
                endcase
            end
        end else if (state_q == KEY_ENTRY && sec_q >= ENTRY_TIMEOUT) begin
            state_d = SHOW_TIME;
            buf_d   = 16'h0000;
        end else if (state_q == SHOW_ALARM && sec_q >= ALARM_TIMEOUT) begin
            state_d = SHOW_TIME;
        end
    end

    // Inactivity counter: any key or any state change restarts the timeout.
    always_comb begin
        sec_d = sec_q;
        if (key_valid || state_d != state_q) begin
            sec_d = 4'd0;
        end else if (one_second && sec_q != SEC_MAX) begin
            sec_d = sec_q + 4'd1;
        end
    end

    // A match on a time update beats the minute clear; STOP and disarm beat all.
    assign alarm_hit = alarm_enable && (time_load || one_minute) && (time_next == alarm_q);

    always_comb begin
        sound_d = sound_q;
        if (stop_key || !alarm_enable) begin
            sound_d = 1'b0;
        end else if (alarm_hit) begin
            sound_d = 1'b1;
        end else if (one_minute) begin
            sound_d = 1'b0;
        end
    end

    always_comb begin
        disp_sel_d = state_d;
        case (state_d)
            KEY_ENTRY:  disp_bcd_d = buf_d;
            SHOW_ALARM: disp_bcd_d = alarm_d;
            default:    disp_bcd_d = time_next;
        endcase
    end

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            state_q    <= SHOW_TIME;
            buf_q      <= 16'h0000;
            alarm_q    <= 16'h0000;
            sec_q      <= 4'd0;
            fast_q     <= 1'b0;
            sound_q    <= 1'b0;
            disp_bcd_q <= 16'h0000;
            disp_sel_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            alarm_q    <= alarm_d;
            sec_q      <= sec_d;
            fast_q     <= fast_d;
            sound_q    <= sound_d;
            disp_bcd_q <= disp_bcd_d;
            disp_sel_q <= disp_sel_d;
        end
    end

    assign fast_mode   = fast_q;
    assign sound_alarm = sound_q;
    assign disp_bcd    = disp_bcd_q;
    assign disp_sel    = disp_sel_q;

endmodule
